alu_imm_datapath: RTL and testbench

Execute-stage datapath slice combining a sign-extending immediate generator, a 16-bit signed ALU and the operand/result pipeline registers between them. Register-file operands A and B plus a 12-bit instruction immediate field come in; the registered immediate and the registered ALU result go out. It sits between the register-file read stage and write-back. All storage is built from one 16-bit register primitive with write enable tied high.

---
 rtl/alu_imm_datapath.sv | 100 ++++++++++
 tb/tb_alu_imm_datapath.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_imm_datapath.sv
// alu_imm_datapath: execute-stage slice built from an immediate generator, a 16-bit
// signed ALU and the pipeline registers around them.
//
// Ports:
//   CLK       in   clock, rising-edge
//   reset     in   synchronous active-high reset, clears all state
//   A, B      in   16-bit signed register-file operands
//   din       in   12-bit raw immediate field
//   numBits   in   field width select: 00=4, 01=6, 10=8, 11=12 bits
//   immShift  in   immediate left shift 0..3
//   ALUSrcB   in   operand-B select: 0 = registered B, 1 = immediate register
//   ALUOp     in   ALU operation select
//   immGen    out  registered immediate, 2 cycles after din
//   ALUOut    out  registered ALU result, 6 cycles after A/B/din
module alu_imm_datapath (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [11:0] din,
  input  logic [1:0]  numBits,
  input  logic [1:0]  immShift,
  input  logic        ALUSrcB,
  input  logic [2:0]  ALUOp,
  output logic [15:0] immGen,
  output logic [15:0] ALUOut
);

  logic [15:0] a_q, b_q, imm_q;
  logic [15:0] opa_q, opb_q, imm_out_q;
  logic [15:0] res_q, dly1_q, dly2_q, alu_out_q;

  logic [15:0] sext;
  logic [15:0] imm_d;
  logic [15:0] opb_d;
  logic [15:0] res_d;

  // Sign-extend the selected field from its top bit, then shift with zero fill.
  always_comb begin
    sext = 16'h0000;
    unique case (numBits)
      2'b00: sext = {{12{din[3]}}, din[3:0]};
      2'b01: sext = {{10{din[5]}}, din[5:0]};
      2'b10: sext = {{8{din[7]}}, din[7:0]};
      2'b11: sext = {{4{din[11]}}, din[11:0]};
      default: sext = 16'h0000;
    endcase
    imm_d = sext << immShift;
  end

  // ALUSrcB is applied one stage after capture, against the already-registered immediate.
  always_comb begin
    opb_d = ALUSrcB ? imm_q : b_q;
  end

  always_comb begin
    res_d = 16'h0000;
    unique case (ALUOp)
      3'b000: res_d = opa_q + opb_q;
      3'b001: res_d = opa_q - opb_q;
      3'b010: res_d = opa_q & opb_q;
      3'b011: res_d = opa_q | opb_q;
      3'b100: res_d = opa_q ^ opb_q;
      3'b101: res_d = opa_q << opb_q[3:0];
      3'b110: res_d = $signed(opa_q) >>> opb_q[3:0];
      3'b111: res_d = ($signed(opa_q) < $signed(opb_q)) ? 16'd1 : 16'd0;
      default: res_d = 16'h0000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      imm_q     <= 16'h0000;
      opa_q     <= 16'h0000;
      opb_q     <= 16'h0000;
      imm_out_q <= 16'h0000;
      res_q     <= 16'h0000;
      dly1_q    <= 16'h0000;
      dly2_q    <= 16'h0000;
      alu_out_q <= 16'h0000;
    end else begin
      a_q       <= A;
      b_q       <= B;
      imm_q     <= imm_d;
      opa_q     <= a_q;
      opb_q     <= opb_d;
      imm_out_q <= imm_q;
      res_q     <= res_d;
      dly1_q    <= res_q;
      dly2_q    <= dly1_q;
      alu_out_q <= dly2_q;
    end
  end

  assign immGen = imm_out_q;
  assign ALUOut = alu_out_q;

endmodule

// File: tb/tb_alu_imm_datapath.sv
// Self-checking bench for alu_imm_datapath: directed scenarios plus random traffic,
// every cycle compared against a history-based reference model.
module tb_alu_imm_datapath;

  localparam int MaxE = 1023;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] A, B;
  logic [11:0] din;
  logic [1:0]  numBits, immShift;
  logic        ALUSrcB;
  logic [2:0]  ALUOp;
  logic [15:0] immGen, ALUOut;

  alu_imm_datapath dut (
    .CLK      (CLK),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .din      (din),
    .numBits  (numBits),
    .immShift (immShift),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .immGen   (immGen),
    .ALUOut   (ALUOut)
  );

  always #5 CLK = ~CLK;

  // Input history indexed by edge number (edge 1 is the first edge).
  logic        h_rst [0:MaxE];
  logic [15:0] h_a   [0:MaxE];
  logic [15:0] h_b   [0:MaxE];
  logic [11:0] h_din [0:MaxE];
  logic [1:0]  h_nb  [0:MaxE];
  logic [1:0]  h_sh  [0:MaxE];
  logic        h_src [0:MaxE];
  logic [2:0]  h_op  [0:MaxE];

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  // Values to drive on the next edge.
  logic        v_rst;
  logic [15:0] v_a, v_b;
  logic [11:0] v_din;
  logic [1:0]  v_nb, v_sh;
  logic        v_src;
  logic [2:0]  v_op;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h, expected %h", tag, edge_n, got, exp);
    end
  endtask

  function automatic int to_s16(input logic [15:0] v);
    return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic logic [15:0] imm_model(input logic [11:0] d, input logic [1:0] nb,
                                            input logic [1:0] sh);
    int w, field, val;
    w = (nb == 2'd0) ? 4 : (nb == 2'd1) ? 6 : (nb == 2'd2) ? 8 : 12;
    field = int'(d) % (1 << w);
    val = (field >= (1 << (w - 1))) ? field - (1 << w) : field;
    val = val * (1 << sh);
    return 16'(val);
  endfunction

  function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
    int ai, bi, s, r;
    ai = to_s16(a);
    bi = to_s16(b);
    s  = int'(b) % 16;
    case (op)
      3'd0: r = ai + bi;
      3'd1: r = ai - bi;
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = ai * (1 << s);
      3'd6: r = ai >>> s;
      default: r = (ai < bi) ? 1 : 0;
    endcase
    return 16'(r);
  endfunction

  function automatic logic [15:0] exp_imm(input int m);
    if (m < 2) return 16'h0;
    for (int j = m - 1; j <= m; j++) if (h_rst[j]) return 16'h0;
    return imm_model(h_din[m-1], h_nb[m-1], h_sh[m-1]);
  endfunction

  function automatic logic [15:0] exp_alu(input int m);
    int k;
    logic [15:0] opb;
    if (m < 6) return 16'h0;
    for (int j = m - 5; j <= m; j++) if (h_rst[j]) return 16'h0;
    k = m - 5;
    opb = h_src[k+1] ? imm_model(h_din[k], h_nb[k], h_sh[k]) : h_b[k];
    return alu_model(h_a[k], opb, h_op[k+2]);
  endfunction

  // One clock: record and drive v_*, clock, then check both outputs against the model.
  task automatic step();
    edge_n++;
    if (edge_n >= MaxE) begin
      $display("FAIL edge_budget: got %0d edges, limit %0d", edge_n, MaxE);
      $fatal(1);
    end
    h_rst[edge_n] = v_rst;  h_a[edge_n]  = v_a;   h_b[edge_n]   = v_b;
    h_din[edge_n] = v_din;  h_nb[edge_n] = v_nb;  h_sh[edge_n]  = v_sh;
    h_src[edge_n] = v_src;  h_op[edge_n] = v_op;
    reset = v_rst; A = v_a; B = v_b; din = v_din; numBits = v_nb; immShift = v_sh;
    ALUSrcB = v_src; ALUOp = v_op;
    @(posedge CLK);
    @(negedge CLK);
    check_eq("model_imm", immGen, exp_imm(edge_n));
    check_eq("model_alu", ALUOut, exp_alu(edge_n));
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [15:0] sweep_exp [1:7];

  initial begin
    sweep_exp[1] = 16'h7FFD; sweep_exp[2] = 16'h0000; sweep_exp[3] = 16'h8005;
    sweep_exp[4] = 16'h8005; sweep_exp[5] = 16'h0010; sweep_exp[6] = 16'hF800;
    sweep_exp[7] = 16'h0001;
    h_rst[0] = 1'b1;
    @(negedge CLK);

    // Reset with nonzero inputs.
    v_rst = 1'b1; v_a = 16'h1234; v_b = 16'h5678; v_din = 12'hABC; v_nb = 2'd3;
    v_sh = 2'd2; v_src = 1'b1; v_op = 3'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_imm", immGen, 16'h0);
      check_eq("rst_alu", ALUOut, 16'h0);
    end

    // Add with register B; outputs stay 0 until their latency elapses.
    v_rst = 1'b0; v_a = 16'd5; v_b = 16'hFFFD; v_src = 1'b0; v_op = 3'd0;
    step();
    check_eq("rel_imm_still0", immGen, 16'h0);
    hold(4);
    check_eq("rel_alu_still0", ALUOut, 16'h0);
    step();
    check_eq("add_regb", ALUOut, 16'd2);

    // Immediate path.
    v_din = 12'h0F8; v_nb = 2'd2; v_sh = 2'd1; v_a = 16'd100; v_src = 1'b1; v_op = 3'd0;
    hold(2);
    check_eq("imm_fff0", immGen, 16'hFFF0);
    hold(4);
    check_eq("add_imm", ALUOut, 16'd84);

    // Op sweep.
    v_a = 16'h8001; v_b = 16'd4; v_src = 1'b0;
    for (int op = 1; op <= 7; op++) begin
      v_op = 3'(op);
      hold(6);
      check_eq($sformatf("sweep_op%0d", op), ALUOut, sweep_exp[op]);
    end

    // Overflow wrap and immediate sign extension.
    v_a = 16'h7FFF; v_b = 16'd1; v_op = 3'd0; v_din = 12'h008; v_nb = 2'd0; v_sh = 2'd0;
    hold(2);
    check_eq("imm_sext", immGen, 16'hFFF8);
    hold(4);
    check_eq("add_wrap", ALUOut, 16'h8000);

    // Back-to-back stream, then a mid-stream reset.
    v_b = 16'd10; v_op = 3'd0; v_src = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      v_a = 16'(i);
      step();
      if (i >= 6) check_eq("stream", ALUOut, 16'(10 + i - 5));
    end
    v_rst = 1'b1; v_a = 16'd13;
    step();
    check_eq("flush_alu", ALUOut, 16'h0);
    v_rst = 1'b0;
    for (int i = 14; i <= 18; i++) begin
      v_a = 16'(i);
      step();
      check_eq("flush_hold0", ALUOut, 16'h0);
    end
    v_a = 16'd19;
    step();
    check_eq("resume", ALUOut, 16'd24);

    // Random traffic with occasional resets and per-cycle control changes.
    for (int i = 0; i < 400; i++) begin
      v_rst = ($urandom_range(0, 31) == 0);
      v_a   = 16'($urandom);
      v_b   = 16'($urandom);
      v_din = 12'($urandom);
      v_nb  = 2'($urandom);
      v_sh  = 2'($urandom);
      v_src = 1'($urandom);
      v_op  = 3'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
